// File: rtl/seq_detector_param_if.sv
// Serial pattern detector bus: bit stream, pattern load,
// counter clear and detection results.
interface seq_detector_param_if #(
  parameter int WIDTH   = 2,
  parameter int COUNT_W = 8
);
  logic               in_valid;
  logic               in_bit;
  logic               pat_load;
  logic [WIDTH-1:0]   pat_in;
  logic               count_clr;
  logic               detected;
  logic [COUNT_W-1:0] match_count;
  logic [WIDTH-1:0]   pattern;

  modport master (
    output in_valid, in_bit, pat_load, pat_in, count_clr,
    input  detected, match_count, pattern
  );

  modport slave (
    input  in_valid, in_bit, pat_load, pat_in, count_clr,
    output detected, match_count, pattern
  );
endinterface

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with loadable pattern,
// overlap/non-overlap mode and saturating match counter.
module seq_detector_param #(
  parameter int               WIDTH           = 2,
  parameter logic [WIDTH-1:0] DEFAULT_PATTERN = WIDTH'(2'b11),
  parameter bit               OVERLAP         = 1'b1,
  parameter int               COUNT_W         = 8
) (
  input logic                 clk,
  input logic                 reset,
  seq_detector_param_if.slave bus
);
  localparam int FW = $clog2(WIDTH + 1);
  localparam logic [FW-1:0] FULL = FW'(WIDTH);
  localparam logic [FW-1:0] LAST = FW'(WIDTH - 1);

  // Oldest history bit never reaches the comparator, so only
  // the newest WIDTH-1 bits are kept.
  logic [WIDTH-2:0]   history;
  logic [FW-1:0]      fill;
  logic [WIDTH-1:0]   pattern_q;
  logic [COUNT_W-1:0] count_q;
  logic               detected_q;

  logic [WIDTH-1:0] window;
  logic             consume;
  logic             hit;

  always_comb begin
    window  = {history, bus.in_bit};
    consume = bus.in_valid && !bus.pat_load;
    hit     = consume && (fill >= LAST) && (window == pattern_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      history    <= '0;
      fill       <= '0;
      pattern_q  <= DEFAULT_PATTERN;
      count_q    <= '0;
      detected_q <= 1'b0;
    end else begin
      detected_q <= hit;
      if (bus.pat_load) begin
        pattern_q <= bus.pat_in;
        fill      <= '0;
      end else if (consume) begin
        history <= window[WIDTH-2:0];
        if (hit && !OVERLAP)
          fill <= '0;
        else if (fill != FULL)
          fill <= fill + FW'(1);
      end
      if (bus.count_clr)
        count_q <= '0;
      else if (hit && count_q != '1)
        count_q <= count_q + COUNT_W'(1);
    end
  end

  assign bus.detected    = detected_q;
  assign bus.match_count = count_q;
  assign bus.pattern     = pattern_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: four parameter sets
// share one stimulus stream, each step checks one instance.
module tb_seq_detector_param;
  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_bit, pat_load, count_clr;
  logic [15:0] pat_in;

  always #5 clk = ~clk;

  seq_detector_param_if #(.WIDTH(2), .COUNT_W(8)) b0 ();
  seq_detector_param_if #(.WIDTH(3), .COUNT_W(8)) b1 ();
  seq_detector_param_if #(.WIDTH(3), .COUNT_W(8)) b2 ();
  seq_detector_param_if #(.WIDTH(2), .COUNT_W(2)) b3 ();

  assign b0.in_valid = in_valid;  assign b1.in_valid = in_valid;
  assign b2.in_valid = in_valid;  assign b3.in_valid = in_valid;
  assign b0.in_bit = in_bit;      assign b1.in_bit = in_bit;
  assign b2.in_bit = in_bit;      assign b3.in_bit = in_bit;
  assign b0.pat_load = pat_load;  assign b1.pat_load = pat_load;
  assign b2.pat_load = pat_load;  assign b3.pat_load = pat_load;
  assign b0.count_clr = count_clr; assign b1.count_clr = count_clr;
  assign b2.count_clr = count_clr; assign b3.count_clr = count_clr;
  assign b0.pat_in = pat_in[1:0]; assign b1.pat_in = pat_in[2:0];
  assign b2.pat_in = pat_in[2:0]; assign b3.pat_in = pat_in[1:0];

  seq_detector_param u0 (.clk(clk), .reset(reset), .bus(b0));
  seq_detector_param #(
    .WIDTH(3), .DEFAULT_PATTERN(3'b101), .OVERLAP(1'b1)
  ) u1 (.clk(clk), .reset(reset), .bus(b1));
  seq_detector_param #(
    .WIDTH(3), .DEFAULT_PATTERN(3'b101), .OVERLAP(1'b0)
  ) u2 (.clk(clk), .reset(reset), .bus(b2));
  seq_detector_param #(
    .WIDTH(2), .COUNT_W(2)
  ) u3 (.clk(clk), .reset(reset), .bus(b3));

  typedef struct {
    int          idx;
    int          sel;
    logic        det;
    logic [7:0]  cnt;
    logic [15:0] pat;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int step_no = 0;
  logic [15:0] exp_pat;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic        a_det;
      logic [7:0]  a_cnt;
      logic [15:0] a_pat;
      e = q.pop_front();
      a_det = 1'b0; a_cnt = '0; a_pat = '0;
      case (e.sel)
        0: begin a_det = b0.detected; a_cnt = 8'(b0.match_count);
                 a_pat = 16'(b0.pattern); end
        1: begin a_det = b1.detected; a_cnt = 8'(b1.match_count);
                 a_pat = 16'(b1.pattern); end
        2: begin a_det = b2.detected; a_cnt = 8'(b2.match_count);
                 a_pat = 16'(b2.pattern); end
        default: begin a_det = b3.detected;
                 a_cnt = 8'(b3.match_count);
                 a_pat = 16'(b3.pattern); end
      endcase
      checks++;
      if (a_det !== e.det || a_cnt !== e.cnt || a_pat !== e.pat) begin
        failures++;
        $display("FAIL step%0d dut%0d: got det=%b cnt=%0d pat=%h exp det=%b cnt=%0d pat=%h",
                 e.idx, e.sel, a_det, a_cnt, a_pat, e.det, e.cnt, e.pat);
      end
    end
  end

  task automatic go(input int sel, input logic r, input logic v,
                    input logic b, input logic pl,
                    input logic [15:0] pi, input logic cc,
                    input logic ed, input logic [7:0] ec);
    exp_t e;
    reset = r; in_valid = v; in_bit = b;
    pat_load = pl; pat_in = pi; count_clr = cc;
    e.idx = step_no; e.sel = sel; e.det = ed;
    e.cnt = ec; e.pat = exp_pat;
    q.push_back(e);
    step_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic rst(input int sel);
    go(sel, 1, 1, 1, 1, 16'h0, 1, 0, 0);
  endtask

  task automatic bt(input int sel, input logic b,
                    input logic ed, input logic [7:0] ec);
    go(sel, 0, 1, b, 0, 16'h0, 0, ed, ec);
  endtask

  task automatic idle(input int sel, input logic [7:0] ec);
    go(sel, 0, 0, 1, 0, 16'h0, 0, 0, ec);
  endtask

  initial begin
    // default params, pattern 11, overlap
    exp_pat = 16'h3;
    rst(0);
    bt(0, 0, 0, 0); bt(0, 0, 0, 0); bt(0, 1, 0, 0);
    bt(0, 1, 1, 1); bt(0, 0, 0, 1); bt(0, 1, 0, 1);
    bt(0, 1, 1, 2); idle(0, 2);

    // width 3, 101, overlap
    exp_pat = 16'h5;
    rst(1);
    bt(1, 1, 0, 0); bt(1, 0, 0, 0); bt(1, 1, 1, 1);
    bt(1, 0, 0, 1); bt(1, 1, 1, 2); idle(1, 2);

    // same stream without overlap
    rst(2);
    bt(2, 1, 0, 0); bt(2, 0, 0, 0); bt(2, 1, 1, 1);
    bt(2, 0, 0, 1); bt(2, 1, 0, 1); idle(2, 1);

    // gaps do not break a partial sequence
    rst(1);
    bt(1, 1, 0, 0); bt(1, 0, 0, 0);
    idle(1, 0); idle(1, 0); idle(1, 0);
    bt(1, 1, 1, 1); idle(1, 1);

    // pattern load restarts fill; input bit ignored on load edge
    rst(1);
    bt(1, 1, 0, 0); bt(1, 0, 0, 0);
    exp_pat = 16'h3;
    go(1, 0, 1, 1, 1, 16'h3, 0, 0, 0);
    bt(1, 1, 0, 0); bt(1, 1, 0, 0);
    bt(1, 0, 0, 0); bt(1, 1, 0, 0); bt(1, 1, 1, 1);
    idle(1, 1);

    // 2-bit counter saturation, clear wins over match
    exp_pat = 16'h3;
    rst(3);
    bt(3, 1, 0, 0);
    bt(3, 1, 1, 1); bt(3, 1, 1, 2); bt(3, 1, 1, 3);
    bt(3, 1, 1, 3); bt(3, 1, 1, 3);
    go(3, 0, 1, 1, 0, 16'h0, 1, 1, 0);
    idle(3, 0);

    // reset discards a partial sequence
    rst(0);
    bt(0, 1, 0, 0);
    rst(0);
    bt(0, 1, 0, 0); bt(0, 1, 1, 1);
    // clear without disturbing history
    go(0, 0, 1, 1, 0, 16'h0, 1, 1, 0);
    go(0, 0, 0, 0, 0, 16'h0, 1, 0, 0);
    bt(0, 1, 1, 1);
    idle(0, 1);

    reset = 1'b0; in_valid = 1'b0; pat_load = 1'b0; count_clr = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, exp 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, giving pattern length in bits (legal range 2..16).
REQ-002 The block SHALL have parameter DEFAULT_PATTERN, default 2'b11 (WIDTH bits), giving the pattern loaded at reset.
REQ-003 The block SHALL have parameter OVERLAP, default 1, where 1 selects overlapping detection and 0 selects non-overlapping detection.
REQ-004 The block SHALL have parameter COUNT_W, default 8, giving the width of the detection counter.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 in_valid  input  1  qualifies in_bit; a bit is consumed only on an edge where in_valid=1.
REQ-009 in_bit  input  1  serial data bit.
REQ-010 pat_load  input  1  loads pat_in as the new pattern on the edge where it is high.
REQ-011 pat_in  input  WIDTH  new pattern; bit WIDTH-1 is the first bit received, bit 0 the last.
REQ-012 count_clr  input  1  clears the detection counter.
REQ-013 detected  output  1  registered one-cycle pulse per match.
REQ-014 match_count  output  COUNT_W  saturating count of matches.
REQ-015 pattern  output  WIDTH  currently active pattern register.

Function
REQ-016 The block SHALL keep a WIDTH-bit history shift register and a fill counter (0..WIDTH, saturating at WIDTH) counting bits consumed since the last restart.
REQ-017 On a consumed bit, history SHALL shift left with in_bit entering bit 0, and fill SHALL increment (saturating).
REQ-018 A match SHALL occur on an edge where in_valid=1, pat_load=0, fill >= WIDTH-1 (before increment), and {history[WIDTH-2:0], in_bit} equals pattern.
REQ-019 detected SHALL be 1 for exactly the cycle after a matching edge and 0 in every other cycle; there is no combinational path from in_bit to detected.
REQ-020 With OVERLAP=1, a match SHALL NOT alter fill, so a suffix of one match can begin the next.
REQ-021 With OVERLAP=0, a match SHALL set fill to 0 on the same edge, so no bit of a matched sequence contributes to a later match.
REQ-022 Edges with in_valid=0 SHALL leave history and fill unchanged and SHALL drive detected to 0; gaps do not break a sequence in progress.
REQ-023 On an edge with pat_load=1, pattern SHALL take pat_in, fill SHALL become 0, detected SHALL be 0 next cycle, and in_valid/in_bit SHALL be ignored on that edge.
REQ-024 match_count SHALL increment by 1 on each matching edge and SHALL saturate at 2^COUNT_W-1.
REQ-025 On an edge with count_clr=1, match_count SHALL become 0; if a match occurs on the same edge, the clear wins (count 0) while detected still pulses.
REQ-026 count_clr SHALL NOT affect history, fill or pattern.

Reset
REQ-027 On an edge with reset=1: detected=0, match_count=0, fill=0, history=0, pattern=DEFAULT_PATTERN; reset overrides pat_load, count_clr and in_valid.
REQ-028 Reset asserted mid-sequence SHALL discard all partially received bits; detection restarts from an empty history.

Verification
REQ-029 Default params (WIDTH=2, pattern 11, OVERLAP=1), bits 0,0,1,1,0,1,1 -> detected pulses after the 4th and 7th bits; match_count=2.
REQ-030 WIDTH=3, DEFAULT_PATTERN=101, OVERLAP=1, bits 1,0,1,0,1 -> detected after bits 3 and 5, count=2; same stream with OVERLAP=0 -> detected after bit 3 only, count=1.
REQ-031 WIDTH=3, pattern 101, bits 1,0 then 3 cycles in_valid=0 then bit 1 -> detected pulses once after the final bit; detected stays 0 during the gap.
REQ-032 WIDTH=3, bits 1,0 then pat_load with pat_in=011, then bits 1,1 -> no detect (fill restarted); then bits 0,1,1 -> detected after the last 1; pattern output reads 011.
REQ-033 COUNT_W=2, 5 matches -> match_count reads 3 after the 3rd and stays 3; count_clr on the same edge as a 6th match -> count=0, detected=1.
REQ-034 WIDTH=2, pattern 11, bit 1 then reset for 1 cycle then bit 1 -> no detect; a further bit 1 -> detected pulses, count=1.
